// File: rtl/timer_arbiter_pkg.sv
// Shared types and constants for the timer arbiter and its counter.
package timer_arbiter_pkg;

  localparam int N_REQ = 2;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/timer_arbiter_mod16_counter.sv
// Free-running mod-16 up-counter with synchronous preload.
module mod16_counter
  import timer_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             preload,
  input  logic [CNT_W-1:0] load,
  output logic [CNT_W-1:0] count
);

  // Preload beats enable; the increment wraps naturally at the 4-bit boundary.
  always_ff @(posedge clk) begin
    if (reset)        count <= '0;
    else if (preload) count <= load;
    else if (enable)  count <= count + 1'b1;
  end

endmodule

// File: rtl/timer_arbiter.sv
// Two-requester round-robin arbiter sharing one interval timer.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | no owner; arbitrate among requests, latch winner's length
//   LOAD  | preload counter with 15 - len
//   RUN   | count up until 15; owner dropping req aborts
//   DONE  | one-cycle done pulse to the owner, then back to IDLE
module timer_arbiter
  import timer_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [CNT_W-1:0] len0,
  input  logic [CNT_W-1:0] len1,
  output logic [N_REQ-1:0] gnt,
  output logic [N_REQ-1:0] done,
  output logic             busy,
  output logic [CNT_W-1:0] count
);

  state_t           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             last_q, last_d;
  logic             win;
  logic             sel;
  logic             preload, enable;
  logic [CNT_W-1:0] load;

  // The owner index is recovered from the one-hot grant.
  assign win  = gnt_q[1];
  assign load = CNT_MAX - len_q;
  assign gnt  = gnt_q;
  assign busy = (state_q != IDLE);

  // State, grant, latched length and round-robin history registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      len_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      len_q   <= len_d;
      last_q  <= last_d;
    end
  end

  // Next-state, arbitration and counter control.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    len_d   = len_q;
    last_d  = last_q;
    preload = 1'b0;
    enable  = 1'b0;
    done    = '0;
    sel     = (req == 2'b11) ? ~last_q : req[1];
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (|req) begin
          gnt_d   = sel ? 2'b10 : 2'b01;
          len_d   = sel ? len1 : len0;
          last_d  = sel;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (!req[win]) begin
          gnt_d   = '0;
          state_d = IDLE;
        end else begin
          preload = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!req[win]) begin
          gnt_d   = '0;
          state_d = IDLE;
        end else if (count == CNT_MAX) begin
          state_d = DONE;
        end else begin
          enable = 1'b1;
        end
      end
      DONE: begin
        done    = gnt_q;
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  mod16_counter u_cnt (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .preload (preload),
    .load    (load),
    .count   (count)
  );

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter with a per-cycle transaction-level model.
module tb_timer_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] req = 2'b00;
  logic [3:0] len0 = 4'd0;
  logic [3:0] len1 = 4'd0;
  logic [1:0] gnt;
  logic [1:0] done;
  logic       busy;
  logic [3:0] count;

  int tests = 0;
  int fails = 0;

  timer_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .len0  (len0),
    .len1  (len1),
    .gnt   (gnt),
    .done  (done),
    .busy  (busy),
    .count (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s got %0d want %0d at %0t", nm, got, want, $time);
    end
  endtask

  // Model: an owner with a cycle index since grant (0 = load cycle),
  // the interval ends at index len+2; count is pure arithmetic on that index.
  int m_owner = -1;
  int m_e = 0;
  int m_len = 0;
  int m_last = 1;
  int m_hold = 0;
  bit m_valid = 1'b0;

  always @(negedge clk) begin
    int eg, ed, eb, ec, w;
    eg = 0; ed = 0; eb = 0; ec = m_hold;
    if (m_owner >= 0) begin
      eg = 1 << m_owner;
      eb = 1;
      ed = (m_e == m_len + 2) ? eg : 0;
      if (m_e == 0)               ec = m_hold;
      else if (m_e >= m_len + 1)  ec = 15;
      else                        ec = 15 - m_len + m_e - 1;
    end
    if (m_valid) begin
      chk("model_gnt", int'(gnt), eg);
      chk("model_done", int'(done), ed);
      chk("model_busy", int'(busy), eb);
      chk("model_count", int'(count), ec);
    end
    if (reset) begin
      m_owner = -1; m_hold = 0; m_last = 1; m_e = 0; m_valid = 1'b1;
    end else if (m_valid) begin
      if (m_owner < 0) begin
        if (req != 2'b00) begin
          if (req == 2'b11) w = 1 - m_last;
          else              w = (req == 2'b10) ? 1 : 0;
          m_owner = w; m_last = w; m_e = 0;
          m_len = (w == 1) ? int'(len1) : int'(len0);
        end
      end else if (m_e == m_len + 2) begin
        m_hold = 15; m_owner = -1;
      end else if (req[m_owner] == 1'b0) begin
        m_hold = ec; m_owner = -1;
      end else begin
        m_e++;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; req = 2'b00;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Counts cycles from the arbitration cycle (n = 0) to the done pulse.
  task automatic wait_done(output int nd, output int ng, output int c2, output int dm);
    nd = -1; ng = -1; c2 = -1; dm = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (ng < 0 && gnt != 2'b00) ng = n;
      if (n == 2) c2 = int'(count);
      if (done != 2'b00) begin
        nd = n; dm = int'(done);
        break;
      end
    end
    if (nd < 0) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int nd, ng, c2, dm;

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_done", int'(done), 0);

    // Single request, len0 = 5
    @(posedge clk); #1;
    len0 = 4'd5; req = 2'b01;
    wait_done(nd, ng, c2, dm);
    chk("single_gnt_lat", ng, 1);
    chk("single_cnt_first", c2, 10);
    chk("single_done_lat", nd, 8);
    chk("single_done_val", dm, 1);
    @(posedge clk); #1;
    req = 2'b00;
    @(negedge clk);
    chk("single_busy_after", int'(busy), 0);

    // Tie after reset: requester 0 first, then 1
    do_reset();
    len0 = 4'd2; len1 = 4'd3; req = 2'b11;
    wait_done(nd, ng, c2, dm);
    chk("tie_first_done_lat", nd, 5);
    chk("tie_first_done_val", dm, 1);
    @(posedge clk); #1;
    req = 2'b10;
    wait_done(nd, ng, c2, dm);
    chk("tie_second_gnt_lat", ng, 1);
    chk("tie_second_done_lat", nd, 6);
    chk("tie_second_done_val", dm, 2);
    @(posedge clk); #1;
    req = 2'b00;

    // Zero length on requester 1
    do_reset();
    len1 = 4'd0; req = 2'b10;
    wait_done(nd, ng, c2, dm);
    chk("zero_cnt_first", c2, 15);
    chk("zero_done_lat", nd, 3);
    chk("zero_done_val", dm, 2);
    @(posedge clk); #1;
    req = 2'b00;

    // Abort at 4th RUN cycle, then a tie goes to requester 1
    do_reset();
    len0 = 4'd10; req = 2'b01;
    repeat (5) @(posedge clk);
    #1 req = 2'b00;
    @(negedge clk);
    chk("abort_cnt_run4", int'(count), 8);
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_cnt_hold", int'(count), 8);
    @(posedge clk); #1;
    len1 = 4'd1; req = 2'b11;
    wait_done(nd, ng, c2, dm);
    chk("abort_tie_gnt_lat", ng, 1);
    chk("abort_tie_done_val", dm, 2);
    chk("abort_tie_done_lat", nd, 4);
    @(posedge clk); #1;
    req = 2'b00;

    // Reset in the 6th RUN cycle of a 15-tick interval
    do_reset();
    len0 = 4'd15; req = 2'b01;
    repeat (7) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("midrst_cnt_run6", int'(count), 5);
    @(posedge clk); #1;
    reset = 1'b0; req = 2'b00;
    @(negedge clk);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_gnt", int'(gnt), 0);
    chk("midrst_count", int'(count), 0);
    chk("midrst_done", int'(done), 0);
    repeat (20) @(posedge clk);

    // Length change during RUN is ignored
    #1 len0 = 4'd4; req = 2'b01;
    fork
      wait_done(nd, ng, c2, dm);
      begin
        repeat (3) @(posedge clk);
        #1 len0 = 4'd12;
      end
    join
    chk("latch_done_lat", nd, 7);
    chk("latch_done_val", dm, 1);
    @(posedge clk); #1;
    req = 2'b00;
    repeat (5) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/timer_arbiter.md
TIMER_ARBITER -- requirements
Module: timer_arbiter

Interface
REQ-001 Clock and reset: one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high; clears all state.
REQ-004 req  input  2  req[i] = requester i wants a timed interval; held high until done[i] or abort.
REQ-005 len0  input  4  interval length in ticks for requester 0, 0..15.
REQ-006 len1  input  4  interval length in ticks for requester 1, 0..15.
REQ-007 gnt  output  2  one-hot grant; gnt[i] high while requester i owns the counter.
REQ-008 done  output  2  done[i] one-cycle pulse when requester i's interval expires.
REQ-009 busy  output  1  high whenever state != IDLE.
REQ-010 count  output  4  live value of the internal mod-16 counter.

Function
REQ-011 FSM states IDLE, LOAD, RUN, DONE; state registered.
REQ-012 IDLE: no req -> stay; any req -> select winner, latch its len, set gnt, go LOAD next edge.
REQ-013 Arbitration round-robin: one requester -> it wins; both -> winner = requester not served last; last_served updates at every grant.
REQ-014 LOAD: counter preload asserted, load value = 15 - latched len; go RUN.
REQ-015 RUN: counter enable high while count != 15; count == 15 in RUN -> enable low, go DONE.
REQ-016 DONE: done[winner] = 1 for exactly this cycle; go IDLE; gnt clears on entry to IDLE.
REQ-017 Latency: req sampled at edge t0 -> gnt at t0+1 -> count = 15-L at t0+2 -> done pulse at t0+L+3; grant-to-done = L+2 cycles.
REQ-018 len = 0: count = 15 on first RUN cycle; done at t0+3; no counting cycles.
REQ-019 len changes after grant are ignored (latched value used).
REQ-020 Abort: req[winner] low during LOAD or RUN -> IDLE next edge, no done pulse, counter enable low, last_served still updated.
REQ-021 The other requester's req is ignored until IDLE; no preemption.
REQ-022 Back-to-back: from DONE, IDLE always spends one cycle before next grant (no same-cycle regrant).
REQ-023 Counter arithmetic 4-bit unsigned; increment wraps 15 -> 0; preload has priority over enable; counter holds in IDLE and DONE.
REQ-024 gnt, done never have more than one bit set; done[i] implies gnt[i] in that cycle.

Reset
REQ-025 reset high at an edge: state = IDLE, gnt = 00, done = 00, busy = 0, count = 0, last_served = 1 (requester 0 wins first tie).
REQ-026 Reset mid-interval wins over all other inputs; no done pulse emitted for the interrupted interval.

Structure
REQ-027 Shared package holds: state encoding (IDLE, LOAD, RUN, DONE), N_REQ = 2, CNT_W = 4, CNT_MAX = 15.
REQ-028 One sub-module: mod16_counter (clk, reset, enable, preload, load[3:0], count[3:0]), instanced once; FSM and arbiter in timer_arbiter.

Verification
REQ-029 Single request: reset, req = 01, len0 = 5 -> gnt = 01 at t0+1, count 10..15, done = 01 pulse at t0+8, busy low at t0+9.
REQ-030 Tie: req = 11 after reset, len0 = 2, len1 = 3 -> requester 0 served first (done[0] at t0+5), then requester 1 granted after one IDLE cycle, done[1] 6 cycles after its sampling edge.
REQ-031 Zero length: req = 10, len1 = 0 -> count = 15 in first RUN cycle, done = 10 at t0+3.
REQ-032 Abort: req = 01, len0 = 10, drop req0 at 4th RUN cycle -> IDLE next edge, done stays 00, next tie grants requester 1.
REQ-033 Reset mid-run: req = 01, len0 = 15, reset at RUN cycle 6 -> next cycle state IDLE, count = 0, gnt = 00, no done.
REQ-034 Latch check: len0 = 4 at grant, change len0 to 12 during RUN -> done still at t0+7.
